// File: rtl/multiword_adder_sequencer.sv
// ============================================================================
// multiword_adder_sequencer
// ----------------------------------------------------------------------------
// Sequential multi-precision adder/subtractor. Two W = BITS*WORDS bit operands
// are accepted over a valid/ready handshake. They are then added one BITS-wide
// chunk per clock through a single Kogge-Stone prefix adder, LSB chunk first,
// with the carry held in a register between chunks. The full-width result,
// carry-out and signed-overflow flag are returned over a second valid/ready
// handshake.
//
// Subtraction is A + ~B + ~borrow_in. The inverted B is kept in b_q, so the
// overflow test on the operand sign bits is the same for add and subtract.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand request valid
//   in_ready   out  1   high only in IDLE
//   in_a       in   W   operand A
//   in_b       in   W   operand B
//   in_ci      in   1   carry-in (add) / borrow-in (subtract)
//   in_sub     in   1   0: A+B+ci, 1: A-B-borrow
//   out_valid  out  1   result valid, high only in DONE
//   out_ready  in   1   consumer accepts result
//   out_s      out  W   sum / difference
//   out_co     out  1   carry-out; in subtract mode 1 means no borrow
//   out_ovf    out  1   two's-complement overflow of the W-bit result
//   busy       out  1   high in ADD and DONE
// ============================================================================
module multiword_adder_sequencer #(
    parameter int BITS  = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BITS*WORDS-1:0]  in_a,
    input  logic [BITS*WORDS-1:0]  in_b,
    input  logic                   in_ci,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BITS*WORDS-1:0]  out_s,
    output logic                   out_co,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int W      = BITS * WORDS;
    localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    // Number of prefix levels in the Kogge-Stone tree (0 for a 1-bit chunk).
    localparam int LEVELS = (BITS > 1) ? $clog2(BITS) : 0;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic [W-1:0]     s_q,     s_d;
    logic             carry_q, carry_d;

    // Chunk adder interface
    logic [BITS-1:0]  add_a;
    logic [BITS-1:0]  add_b;
    logic [BITS-1:0]  add_s;
    logic             add_co;

    // ------------------------------------------------------------------------
    // Chunk selection: split the operand registers into BITS-wide chunks and
    // select the current one with idx_q.
    // ------------------------------------------------------------------------
    logic [BITS-1:0] a_chunk [WORDS];
    logic [BITS-1:0] b_chunk [WORDS];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[gi*BITS +: BITS];
            assign b_chunk[gi] = b_q[gi*BITS +: BITS];

            // Only the chunk addressed by idx_q is written during ADD; every
            // other chunk of the sum register holds its value.
            assign s_d[gi*BITS +: BITS] =
                ((state_q == ST_ADD) && (idx_q == IDX_W'(gi))) ? add_s
                                                               : s_q[gi*BITS +: BITS];
        end
    endgenerate

    assign add_a = a_chunk[idx_q];
    assign add_b = b_chunk[idx_q];

    // ------------------------------------------------------------------------
    // Kogge-Stone chunk adder
    // Level 0 holds bitwise generate/propagate. Carry-in is folded into the
    // generate of bit 0, so the group generate of span [i:0] after the last
    // level is exactly the carry out of bit i.
    // ------------------------------------------------------------------------
    logic [(LEVELS+1)*BITS-1:0] ks_g;
    logic [(LEVELS+1)*BITS-1:0] ks_p;
    logic [BITS-1:0]            ks_half;   // a ^ b per bit
    logic [BITS-1:0]            ks_cin;    // carry into each bit position

    generate
        for (gi = 0; gi < BITS; gi++) begin : g_ks_l0
            assign ks_half[gi] = add_a[gi] ^ add_b[gi];
            assign ks_p[gi]    = ks_half[gi];
            if (gi == 0) begin : g_bit0
                assign ks_g[gi] = (add_a[gi] & add_b[gi]) | (ks_half[gi] & carry_q);
            end else begin : g_bitn
                assign ks_g[gi] = add_a[gi] & add_b[gi];
            end
        end

        for (genvar lv = 0; lv < LEVELS; lv++) begin : g_ks_lvl
            localparam int D = 1 << lv;
            for (gi = 0; gi < BITS; gi++) begin : g_ks_bit
                if (gi >= D) begin : g_comb
                    // Black cell: merge the group ending at gi with the group
                    // ending D positions below it.
                    assign ks_g[(lv+1)*BITS + gi] =
                        ks_g[lv*BITS + gi] |
                        (ks_p[lv*BITS + gi] & ks_g[lv*BITS + gi - D]);
                    assign ks_p[(lv+1)*BITS + gi] =
                        ks_p[lv*BITS + gi] & ks_p[lv*BITS + gi - D];
                end else begin : g_pass
                    // Group already reaches bit 0: value is final.
                    assign ks_g[(lv+1)*BITS + gi] = ks_g[lv*BITS + gi];
                    assign ks_p[(lv+1)*BITS + gi] = ks_p[lv*BITS + gi];
                end
            end
        end

        assign ks_cin[0] = carry_q;
        for (gi = 1; gi < BITS; gi++) begin : g_ks_cin
            assign ks_cin[gi] = ks_g[LEVELS*BITS + gi - 1];
        end
    endgenerate

    assign add_s  = ks_half ^ ks_cin;
    assign add_co = ks_g[LEVELS*BITS + BITS - 1];

    // The top-level group propagate terms are never needed once the carry-in
    // has been merged into the generate chain.
    logic unused_ks_p;
    assign unused_ks_p = ^ks_p[LEVELS*BITS +: BITS];

    // ------------------------------------------------------------------------
    // FSM next-state and datapath update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    // Subtract as A + ~B + ~borrow.
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_sub ? ~in_ci : in_ci;
                    idx_d   = '0;
                    state_d = ST_ADD;
                end
            end

            ST_ADD: begin
                carry_d = add_co;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only. Result fields are gated
    // with DONE so a partially accumulated sum is never visible.
    // ------------------------------------------------------------------------
    logic done_w;
    assign done_w    = (state_q == ST_DONE);

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = done_w;
    assign busy      = (state_q == ST_ADD) || done_w;
    assign out_s     = done_w ? s_q : '0;
    assign out_co    = done_w & carry_q;
    assign out_ovf   = done_w & (a_q[W-1] == b_q[W-1]) & (s_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
module tb_multiword_adder_sequencer;

    localparam int BITS  = 8;
    localparam int WORDS = 4;
    localparam int W     = BITS * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_co;
    logic         out_ovf;
    logic         busy;

    int total = 0;
    int bad   = 0;

    multiword_adder_sequencer #(.BITS(BITS), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_co    (out_co),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width values.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sub,
                                  output logic [W-1:0] s, output logic co,
                                  output logic ovf);
        longint ua, ub, uc, ur, sa, sb, sr;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        uc = longint'(ci);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!sub) begin
            ur = ua + ub + uc;
            co = (ur >= 64'sh1_0000_0000);
            sr = sa + sb + uc;
        end else begin
            ur = ua - ub - uc;
            co = (ua >= ub + uc);
            sr = sa - sb - uc;
        end
        s   = ur[W-1:0];
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Issue one request (called #1 after a rising edge, DUT idle), wait for
    // the result, return it and the latency in edges after acceptance, then
    // complete the output handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub,
                          output logic [W-1:0] s, output logic co,
                          output logic ovf, output int lat);
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the inputs: the captured operands must not follow them.
        in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom); in_sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL result_timeout: got no out_valid expected out_valid within 20 cycles");
        end
        s = out_s; co = out_co; ovf = out_ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_back", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] s, es;
        logic         co, eco, ovf, eovf;
        int           lat;
        logic [W-1:0] ra, rb;
        logic         rci, rsub;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_ci = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        #22 rst_n = 1'b1;

        // Reset state after idling
        repeat (5) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_s",     64'(out_s),     64'd0);
        chk("rst_out_co",    64'(out_co),    64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        $display("reset check: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, s, co, ovf, lat);
            $display("vec %0d: a=%h b=%h ci=%0b sub=%0b -> s=%h co=%0b ovf=%0b lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, s, co, ovf, lat);
            chk("vec_s",   64'(s),   64'(vecs[i].s));
            chk("vec_co",  64'(co),  64'(vecs[i].co));
            chk("vec_ovf", 64'(ovf), 64'(vecs[i].ovf));
            chk("vec_lat", 64'(lat), 64'(WORDS));
        end

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) ra = 32'hFFFFFFFF;
            if (i % 8 == 1) rb = ~ra;
            rci = 1'($urandom); rsub = 1'($urandom);
            model(ra, rb, rci, rsub, es, eco, eovf);
            run_op(ra, rb, rci, rsub, s, co, ovf, lat);
            $display("rnd %0d: a=%h b=%h ci=%0b sub=%0b -> s=%h co=%0b ovf=%0b (model s=%h co=%0b ovf=%0b)",
                     i, ra, rb, rci, rsub, s, co, ovf, es, eco, eovf);
            chk("rnd_s",   64'(s),   64'(es));
            chk("rnd_co",  64'(co),  64'(eco));
            chk("rnd_ovf", 64'(ovf), 64'(eovf));
            chk("rnd_lat", 64'(lat), 64'(WORDS));
        end

        // Backpressure: result held while out_ready is low, new requests ignored
        model(32'h7FFF0000, 32'h00012345, 1'b0, 1'b0, es, eco, eovf);
        in_a = 32'h7FFF0000; in_b = 32'h00012345; in_ci = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_lat", 64'(lat), 64'(WORDS));
        in_valid = 1'b1; in_a = 32'hDEADBEEF; in_b = 32'hCAFEF00D; in_sub = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ready", 64'(in_ready),  64'd0);
            chk("bp_s",     64'(out_s),     64'(es));
            chk("bp_co",    64'(out_co),    64'(eco));
            chk("bp_ovf",   64'(out_ovf),   64'(eovf));
            @(posedge clk); #1;
        end
        $display("backpressure: held s=%h co=%0b ovf=%0b", out_s, out_co, out_ovf);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 64'(out_valid), 64'd0);
        chk("bp_release_ready", 64'(in_ready),  64'd1);
        model(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, es, eco, eovf);
        run_op(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, s, co, ovf, lat);
        $display("after backpressure: s=%h co=%0b ovf=%0b", s, co, ovf);
        chk("bp_next_s",  64'(s),  64'(es));
        chk("bp_next_co", 64'(co), 64'(eco));

        // Reset asserted during the second ADD cycle
        in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_ci = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy",  64'(busy),      64'd0);
        chk("mid_rst_s",     64'(out_s),     64'd0);
        #1 rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("mid_idle_valid", 64'(out_valid), 64'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, s, co, ovf, lat);
        $display("after reset: s=%h co=%0b ovf=%0b lat=%0d", s, co, ovf, lat);
        chk("mid_next_s",   64'(s),   64'h23456789);
        chk("mid_next_co",  64'(co),  64'd0);
        chk("mid_next_lat", 64'(lat), 64'(WORDS));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
